id_ex_pipe: RTL and testbench
=============================

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter SIZE, default 32, datapath width of PC, operand and immediate buses.
REQ-002 Parameter CTRLW, default 16, width of the packed control bundle (ALUCtrl, DSize, jump/branch flags, etc.).
REQ-003 Parameter CNTW, default 16, width of the bubble counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 valid_in  input  1  decode stage holds a real instruction.
REQ-007 nextPC_in, busA_in, busB_in, imm_in, memVal_in  input  SIZE each  decoded operands from decode.
REQ-008 ctrl_in  input  CTRLW  packed control bundle.
REQ-009 regWrite_in, memToReg_in  input  1 each  writeback controls, kept separate for hazard logic.
REQ-010 rs1_in, rs2_in, rd_in  input  5 each  source and destination register numbers; usesRs2_in  input  1  rs2 is a true source.
REQ-011 stall_in  input  1  downstream stall, hold register; flush_in  input  1  squash, insert bubble; cnt_clr_in  input  1  clear bubble counter.
REQ-012 valid_out, regWrite_out, memToReg_out  output  1 each  registered copies, gated by valid.
REQ-013 nextPC_out, busA_out, busB_out, imm_out, memVal_out  output  SIZE each; ctrl_out  output  CTRLW; destReg_out  output  5.
REQ-014 hazard_out  output  1  combinational load-use interlock request to the PC/IF-ID stages.
REQ-015 bubble_cnt_out  output  CNTW  saturating count of inserted bubbles.

Function
REQ-016 Per rising edge, exactly one action is taken, with priority flush > stall > hazard > load.
REQ-017 Flush (flush_in=1): valid_out, regWrite_out and memToReg_out SHALL become 0; other data outputs SHALL be don't-care, implemented as 0.
REQ-018 Stall (stall_in=1, flush_in=0): all outputs SHALL hold their values.
REQ-019 Hazard (hazard_out=1, no flush/stall): a bubble is loaded as in REQ-017; upstream holds, and the instruction re-presents next cycle.
REQ-020 Load (otherwise): all *_in values SHALL be captured; valid_out=valid_in; regWrite_out and memToReg_out SHALL be ANDed with valid_in; destReg_out=rd_in.
REQ-021 hazard_out = valid_out & memToReg_out & (destReg_out!=0) & valid_in & ((destReg_out==rs1_in) | (usesRs2_in & destReg_out==rs2_in)) & ~flush_in.
REQ-022 hazard_out SHALL remain asserted during stall_in while the condition holds; it SHALL clear after the bubble is loaded, because valid_out is then 0.
REQ-023 Latency: load-to-output is 1 cycle; a load-use pair incurs exactly 1 bubble.
REQ-024 Bubble counter SHALL increment by 1 on each edge taking a flush or hazard action where the register previously held or would have held valid data, i.e. valid_out=1 or valid_in=1 before the edge.
REQ-025 Bubble counter SHALL saturate at all-ones, never wrapping.
REQ-026 cnt_clr_in SHALL zero the counter on the next edge and takes priority over increment.
REQ-027 Register r0 as destination SHALL never cause a hazard.

Reset
REQ-028 While reset=0, all outputs SHALL be 0 immediately (asynchronous), including valid_out, hazard_out and bubble_cnt_out.
REQ-029 Reset asserted mid-stall or mid-hazard SHALL discard held state; the first edge after release performs a normal REQ-016 action.

Configuration
REQ-030 Macro ID_EX_HAZARD_EN: when defined, REQ-019, REQ-021 and REQ-022 apply.
REQ-031 When ID_EX_HAZARD_EN is undefined, hazard_out SHALL be constant 0, no hazard bubbles are inserted, and the counter counts flushes only; forwarding/software scheduling resolves load-use.

Verification
REQ-032 Reset released, valid_in=1, busA_in=32'h0000_1234, rd_in=3 -> after 1 edge: busA_out=32'h0000_1234, destReg_out=3, valid_out=1.
REQ-033 HAZARD_EN: load to rd=5 (memToReg_in=1), then valid_in=1 with rs1_in=5 -> hazard_out=1 for 1 cycle, valid_out=0 next edge, bubble_cnt_out=1, instruction captured the following edge.
REQ-034 Load to rd=0 with memToReg_in=1, then rs1_in=0 -> hazard_out stays 0, no bubble.
REQ-035 stall_in=1 for 3 cycles with changing inputs -> outputs unchanged; flush_in and stall_in together -> valid_out=0.
REQ-036 Force 2^CNTW+2 flushes (CNTW=4: 18) -> bubble_cnt_out=4'hF; cnt_clr_in=1 -> 0 next edge.
REQ-037 Drop reset to 0 between edges with valid_out=1 -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: flush/stall/bubble control and a saturating bubble counter.
// Define ID_EX_HAZARD_EN to enable load-use hazard detection and bubble insertion.
module id_ex_pipe #(
   parameter int unsigned SIZE  = 32,
   parameter int unsigned CTRLW = 16,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [SIZE-1:0]  nextPC_in,
   input  logic [SIZE-1:0]  busA_in,
   input  logic [SIZE-1:0]  busB_in,
   input  logic [SIZE-1:0]  imm_in,
   input  logic [SIZE-1:0]  memVal_in,
   input  logic [CTRLW-1:0] ctrl_in,
   input  logic             regWrite_in,
   input  logic             memToReg_in,
   input  logic [4:0]       rs1_in,
   input  logic [4:0]       rs2_in,
   input  logic [4:0]       rd_in,
   input  logic             usesRs2_in,
   input  logic             stall_in,
   input  logic             flush_in,
   input  logic             cnt_clr_in,
   output logic             valid_out,
   output logic             regWrite_out,
   output logic             memToReg_out,
   output logic [SIZE-1:0]  nextPC_out,
   output logic [SIZE-1:0]  busA_out,
   output logic [SIZE-1:0]  busB_out,
   output logic [SIZE-1:0]  imm_out,
   output logic [SIZE-1:0]  memVal_out,
   output logic [CTRLW-1:0] ctrl_out,
   output logic [4:0]       destReg_out,
   output logic             hazard_out,
   output logic [CNTW-1:0]  bubble_cnt_out
);

   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   logic insertBubble;
   logic countBubble;

`ifdef ID_EX_HAZARD_EN
   // Load in EX whose destination feeds the instruction now in decode.
   assign hazard_out = valid_out & memToReg_out & (destReg_out != 5'd0) & valid_in &
                       ((destReg_out == rs1_in) | (usesRs2_in & (destReg_out == rs2_in))) &
                       ~flush_in;
`else
   logic unusedHazardIn;
   assign unusedHazardIn = ^{rs1_in, rs2_in, usesRs2_in};
   assign hazard_out     = 1'b0;
`endif

   always_comb begin
      insertBubble = 1'b0;
      countBubble  = 1'b0;
      insertBubble = flush_in | (~stall_in & hazard_out);
      countBubble  = insertBubble & (valid_out | valid_in) & (bubble_cnt_out != CNT_MAX);
   end

   // Pipeline payload: flush > stall > hazard bubble > load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_out    <= 1'b0;
         regWrite_out <= 1'b0;
         memToReg_out <= 1'b0;
         nextPC_out   <= '0;
         busA_out     <= '0;
         busB_out     <= '0;
         imm_out      <= '0;
         memVal_out   <= '0;
         ctrl_out     <= '0;
         destReg_out  <= '0;
      end else if (insertBubble) begin
         valid_out    <= 1'b0;
         regWrite_out <= 1'b0;
         memToReg_out <= 1'b0;
         nextPC_out   <= '0;
         busA_out     <= '0;
         busB_out     <= '0;
         imm_out      <= '0;
         memVal_out   <= '0;
         ctrl_out     <= '0;
         destReg_out  <= '0;
      end else if (!stall_in) begin
         valid_out    <= valid_in;
         regWrite_out <= regWrite_in & valid_in;
         memToReg_out <= memToReg_in & valid_in;
         nextPC_out   <= nextPC_in;
         busA_out     <= busA_in;
         busB_out     <= busB_in;
         imm_out      <= imm_in;
         memVal_out   <= memVal_in;
         ctrl_out     <= ctrl_in;
         destReg_out  <= rd_in;
      end
   end

   // Bubble counter saturates; clear wins over increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bubble_cnt_out <= '0;
      end else if (cnt_clr_in) begin
         bubble_cnt_out <= '0;
      end else if (countBubble) begin
         bubble_cnt_out <= bubble_cnt_out + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe (CNTW=4); hazard scenarios follow ID_EX_HAZARD_EN.
module tb_id_ex_pipe;

   typedef struct packed {
      logic        valid;
      logic        regWrite;
      logic        memToReg;
      logic [4:0]  destReg;
      logic [31:0] nextPC;
      logic [31:0] busA;
      logic [31:0] busB;
      logic [31:0] imm;
      logic [31:0] memVal;
      logic [15:0] ctrl;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] nextPC_in = '0, busA_in = '0, busB_in = '0, imm_in = '0, memVal_in = '0;
   logic [15:0] ctrl_in = '0;
   logic        regWrite_in = 1'b0, memToReg_in = 1'b0;
   logic [4:0]  rs1_in = '0, rs2_in = '0, rd_in = '0;
   logic        usesRs2_in = 1'b0, stall_in = 1'b0, flush_in = 1'b0, cnt_clr_in = 1'b0;
   logic        valid_out, regWrite_out, memToReg_out, hazard_out;
   logic [31:0] nextPC_out, busA_out, busB_out, imm_out, memVal_out;
   logic [15:0] ctrl_out;
   logic [4:0]  destReg_out;
   logic [3:0]  bubble_cnt_out;

   int   checks = 0;
   int   failures = 0;
   obs_t q[$];
   obs_t expV, gotV, lastExp;
   logic [3:0] expCnt;

   id_ex_pipe #(.SIZE(32), .CTRLW(16), .CNTW(4)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in),
      .nextPC_in(nextPC_in), .busA_in(busA_in), .busB_in(busB_in), .imm_in(imm_in),
      .memVal_in(memVal_in), .ctrl_in(ctrl_in), .regWrite_in(regWrite_in),
      .memToReg_in(memToReg_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
      .usesRs2_in(usesRs2_in), .stall_in(stall_in), .flush_in(flush_in),
      .cnt_clr_in(cnt_clr_in), .valid_out(valid_out), .regWrite_out(regWrite_out),
      .memToReg_out(memToReg_out), .nextPC_out(nextPC_out), .busA_out(busA_out),
      .busB_out(busB_out), .imm_out(imm_out), .memVal_out(memVal_out),
      .ctrl_out(ctrl_out), .destReg_out(destReg_out), .hazard_out(hazard_out),
      .bubble_cnt_out(bubble_cnt_out)
   );

   always #5 clk = ~clk;

   function automatic obs_t snap();
      obs_t s;
      s = '{valid_out, regWrite_out, memToReg_out, destReg_out, nextPC_out, busA_out,
            busB_out, imm_out, memVal_out, ctrl_out};
      return s;
   endfunction

   // Reference for a plain load action.
   function automatic obs_t loadModel();
      obs_t s;
      s = '{valid_in, regWrite_in & valid_in, memToReg_in & valid_in, rd_in, nextPC_in,
            busA_in, busB_in, imm_in, memVal_in, ctrl_in};
      return s;
   endfunction

   function automatic logic [3:0] satInc(input logic [3:0] c);
      return (c == 4'hF) ? c : c + 4'd1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic randData();
      nextPC_in = $urandom; busA_in = $urandom; busB_in = $urandom;
      imm_in = $urandom; memVal_in = $urandom; ctrl_in = 16'($urandom);
      regWrite_in = 1'($urandom); rd_in = 5'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (snap() !== obs_t'(0)) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", snap());
      end
      checks++;
      if ({hazard_out, bubble_cnt_out} !== 5'b0) begin
         failures++; $display("FAIL reset_haz_cnt got=%b exp=0", {hazard_out, bubble_cnt_out});
      end
      @(negedge clk) reset = 1'b1;
      #1;
      lastExp = '0; expCnt = 4'h0;
   endtask

   task automatic test_load();
      randData();
      valid_in = 1'b1; busA_in = 32'h0000_1234; rd_in = 5'd3; memToReg_in = 1'b0;
      rs1_in = 5'd0; usesRs2_in = 1'b0;
      q.push_back(loadModel());
      tick();
      expV = q.pop_front(); gotV = snap(); lastExp = expV;
      checks++;
      if (gotV !== expV || busA_out !== 32'h0000_1234 || destReg_out !== 5'd3 || valid_out !== 1'b1) begin
         failures++; $display("FAIL load_basic got=%h exp=%h", gotV, expV);
      end
      for (int i = 0; i < 5; i++) begin
         randData();
         valid_in = 1'($urandom); memToReg_in = 1'($urandom);
         q.push_back(loadModel());
         tick();
         expV = q.pop_front(); gotV = snap(); lastExp = expV;
         checks++;
         if (gotV !== expV || bubble_cnt_out !== expCnt) begin
            failures++; $display("FAIL load_rand%0d got=%h/%h exp=%h/%h", i, gotV, bubble_cnt_out, expV, expCnt);
         end
      end
   endtask

   task automatic test_stall();
      randData();
      valid_in = 1'b1; memToReg_in = 1'b1; rs1_in = 5'd0; usesRs2_in = 1'b0;
      q.push_back(loadModel());
      tick();
      expV = q.pop_front(); lastExp = expV;
      checks++;
      if (snap() !== expV) begin
         failures++; $display("FAIL stall_preload got=%h exp=%h", snap(), expV);
      end
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         randData();
         q.push_back(lastExp);
         tick();
         expV = q.pop_front();
         checks++;
         if (snap() !== expV) begin
            failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, snap(), expV);
         end
      end
      flush_in = 1'b1;
      q.push_back(obs_t'(0));
      expCnt = satInc(expCnt);
      tick();
      expV = q.pop_front(); lastExp = expV;
      checks++;
      if (snap() !== expV || bubble_cnt_out !== expCnt) begin
         failures++; $display("FAIL stall_flush got=%h/%h exp=%h/%h", snap(), bubble_cnt_out, expV, expCnt);
      end
      flush_in = 1'b0; stall_in = 1'b0;
   endtask

   task automatic test_hazard();
      randData();
      valid_in = 1'b1; memToReg_in = 1'b1; rd_in = 5'd5; rs1_in = 5'd0; usesRs2_in = 1'b0;
      q.push_back(loadModel());
      tick();
      expV = q.pop_front(); lastExp = expV;
      checks++;
      if (snap() !== expV) begin
         failures++; $display("FAIL haz_load got=%h exp=%h", snap(), expV);
      end
      randData();
      valid_in = 1'b1; rs1_in = 5'd5; memToReg_in = 1'b1; rd_in = 5'd7;
      #1;
`ifdef ID_EX_HAZARD_EN
      checks++;
      if (hazard_out !== 1'b1) begin
         failures++; $display("FAIL haz_assert got=%b exp=1", hazard_out);
      end
      stall_in = 1'b1;
      q.push_back(lastExp);
      tick();
      expV = q.pop_front();
      checks++;
      if (snap() !== expV || hazard_out !== 1'b1) begin
         failures++; $display("FAIL haz_stall got=%h/%b exp=%h/1", snap(), hazard_out, expV);
      end
      stall_in = 1'b0;
      q.push_back(obs_t'(0));
      expCnt = satInc(expCnt);
      tick();
      expV = q.pop_front();
      checks++;
      if (snap() !== expV || hazard_out !== 1'b0 || bubble_cnt_out !== expCnt) begin
         failures++; $display("FAIL haz_bubble got=%h/%b/%h exp=%h/0/%h", snap(), hazard_out, bubble_cnt_out, expV, expCnt);
      end
`else
      checks++;
      if (hazard_out !== 1'b0) begin
         failures++; $display("FAIL haz_disabled got=%b exp=0", hazard_out);
      end
`endif
      q.push_back(loadModel());
      tick();
      expV = q.pop_front();
      checks++;
      if (snap() !== expV || bubble_cnt_out !== expCnt) begin
         failures++; $display("FAIL haz_capture got=%h/%h exp=%h/%h", snap(), bubble_cnt_out, expV, expCnt);
      end
      // Loaded instruction writes r7 from memory; next consumer reads it via rs2.
      randData();
      valid_in = 1'b1; rs1_in = 5'd0; rs2_in = 5'd7; usesRs2_in = 1'b0; memToReg_in = 1'b0;
      #1;
      checks++;
      if (hazard_out !== 1'b0) begin
         failures++; $display("FAIL haz_rs2_unused got=%b exp=0", hazard_out);
      end
      usesRs2_in = 1'b1;
      #1;
`ifdef ID_EX_HAZARD_EN
      checks++;
      if (hazard_out !== 1'b1) begin
         failures++; $display("FAIL haz_rs2 got=%b exp=1", hazard_out);
      end
      q.push_back(obs_t'(0));
      expCnt = satInc(expCnt);
      tick();
      expV = q.pop_front();
      checks++;
      if (snap() !== expV || bubble_cnt_out !== expCnt) begin
         failures++; $display("FAIL haz_rs2_bubble got=%h/%h exp=%h/%h", snap(), bubble_cnt_out, expV, expCnt);
      end
`endif
      q.push_back(loadModel());
      tick();
      expV = q.pop_front();
      checks++;
      if (snap() !== expV) begin
         failures++; $display("FAIL haz_rs2_capture got=%h exp=%h", snap(), expV);
      end
      usesRs2_in = 1'b0;
   endtask

   task automatic test_r0();
      randData();
      valid_in = 1'b1; memToReg_in = 1'b1; rd_in = 5'd0; rs1_in = 5'd0;
      q.push_back(loadModel());
      tick();
      expV = q.pop_front();
      randData();
      valid_in = 1'b1; rs1_in = 5'd0; rd_in = 5'd9;
      #1;
      checks++;
      if (hazard_out !== 1'b0 || snap() !== expV) begin
         failures++; $display("FAIL r0_nohaz got=%b/%h exp=0/%h", hazard_out, snap(), expV);
      end
      q.push_back(loadModel());
      tick();
      expV = q.pop_front();
      checks++;
      if (snap() !== expV || bubble_cnt_out !== expCnt) begin
         failures++; $display("FAIL r0_load got=%h/%h exp=%h/%h", snap(), bubble_cnt_out, expV, expCnt);
      end
   endtask

   task automatic test_saturate();
      flush_in = 1'b1; valid_in = 1'b1;
      for (int i = 0; i < 18; i++) begin
         randData();
         expCnt = satInc(expCnt);
         tick();
      end
      checks++;
      if (bubble_cnt_out !== 4'hF || expCnt !== 4'hF || snap() !== obs_t'(0)) begin
         failures++; $display("FAIL sat_count got=%h exp=f", bubble_cnt_out);
      end
      flush_in = 1'b0; valid_in = 1'b0; cnt_clr_in = 1'b1; memToReg_in = 1'b0;
      q.push_back(loadModel());
      expCnt = 4'h0;
      tick();
      expV = q.pop_front();
      checks++;
      if (bubble_cnt_out !== expCnt || snap() !== expV) begin
         failures++; $display("FAIL sat_clear got=%h/%h exp=%h/%h", bubble_cnt_out, snap(), expCnt, expV);
      end
      // Clear beats a simultaneous flush increment.
      flush_in = 1'b1; valid_in = 1'b1;
      tick();
      checks++;
      if (bubble_cnt_out !== 4'h0) begin
         failures++; $display("FAIL clr_priority got=%h exp=0", bubble_cnt_out);
      end
      flush_in = 1'b0; cnt_clr_in = 1'b0;
   endtask

   task automatic test_async_reset();
      randData();
      valid_in = 1'b1; memToReg_in = 1'b0; rs1_in = 5'd0; usesRs2_in = 1'b0;
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      q.push_back(loadModel());
      tick();
      expV = q.pop_front();
      checks++;
      if (snap() !== expV || valid_out !== 1'b1 || bubble_cnt_out !== 4'h1) begin
         failures++; $display("FAIL areset_pre got=%h/%h exp=%h/1", snap(), bubble_cnt_out, expV);
      end
      stall_in = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (snap() !== obs_t'(0) || hazard_out !== 1'b0 || bubble_cnt_out !== 4'h0) begin
         failures++; $display("FAIL areset_async got=%h/%b/%h exp=0", snap(), hazard_out, bubble_cnt_out);
      end
      tick();
      @(negedge clk);
      reset = 1'b1; stall_in = 1'b0;
      randData();
      valid_in = 1'b1;
      q.push_back(loadModel());
      tick();
      expV = q.pop_front();
      checks++;
      if (snap() !== expV) begin
         failures++; $display("FAIL areset_release got=%h exp=%h", snap(), expV);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_stall();
      test_hazard();
      test_r0();
      test_saturate();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
